// File: rtl/uart_ram_dumper.sv
// Streams a range of RAM words out to the UART TX byte interface, least-significant byte first.
// Define UART_DUMP_CHECKSUM_EN to append a two's-complement checksum byte after the data.
module uart_ram_dumper #(
  parameter int ADDR_LEN = 14,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                dump_start,
  input  logic [ADDR_LEN-1:0] dump_base_addr,
  input  logic [ADDR_LEN:0]   dump_len,
  output logic                dump_busy,
  output logic                dump_done,
  output logic                ram_rd_en,
  output logic [ADDR_LEN-1:0] ram_addr,
  input  logic [XLEN-1:0]     ram_rd_data,
  output logic                uart_tx_valid,
  output logic [7:0]          uart_tx_data,
  input  logic                uart_tx_ready
);

  localparam int BYTES  = XLEN / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND,
`ifdef UART_DUMP_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_LEN-1:0]       r_addr;
  logic [ADDR_LEN-1:0]       r_ram_addr;
  logic [ADDR_LEN:0]         r_count;
  logic [BYTES-1:0][7:0]     r_word;
  logic [BIDX_W-1:0]         r_byte_idx;
  logic                      w_hs;
  logic                      w_last_byte;
  logic                      w_last_word;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]                r_sum;
`endif

  assign w_hs        = uart_tx_valid & uart_tx_ready;
  assign w_last_byte = (r_byte_idx == BIDX_W'(BYTES - 1));
  assign w_last_word = (r_count == (ADDR_LEN+1)'(1));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dump_start) begin
          if (dump_len == '0) begin
`ifdef UART_DUMP_CHECKSUM_EN
            w_next = S_CKSUM;
`else
            w_next = S_DONE;
`endif
          end else begin
            w_next = S_RD_REQ;
          end
        end
      end
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_SEND;
      S_SEND: begin
        if (w_hs && w_last_byte) begin
          if (w_last_word) begin
`ifdef UART_DUMP_CHECKSUM_EN
            w_next = S_CKSUM;
`else
            w_next = S_DONE;
`endif
          end else begin
            w_next = S_RD_REQ;
          end
        end
      end
`ifdef UART_DUMP_CHECKSUM_EN
      S_CKSUM: if (w_hs) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dump_busy     = 1'b0;
    dump_done     = 1'b0;
    ram_rd_en     = 1'b0;
    ram_addr      = r_ram_addr;
    uart_tx_valid = 1'b0;
    uart_tx_data  = 8'h00;
    case (r_state)
      S_RD_REQ: begin
        dump_busy = 1'b1;
        ram_rd_en = 1'b1;
        ram_addr  = r_addr;
      end
      S_RD_WAIT: dump_busy = 1'b1;
      S_SEND: begin
        dump_busy     = 1'b1;
        uart_tx_valid = 1'b1;
        uart_tx_data  = r_word[r_byte_idx];
      end
`ifdef UART_DUMP_CHECKSUM_EN
      S_CKSUM: begin
        dump_busy     = 1'b1;
        uart_tx_valid = 1'b1;
        uart_tx_data  = 8'h00 - r_sum;
      end
`endif
      S_DONE:  dump_done = 1'b1;
      default: ;
    endcase
  end

  // Address and count advance only on the final byte handshake of each word,
  // so valid/data stay frozen for the whole of a stall.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_count    <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_start) begin
            r_addr  <= dump_base_addr;
            r_count <= dump_len;
`ifdef UART_DUMP_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        S_RD_REQ: r_ram_addr <= r_addr;
        S_RD_WAIT: begin
          r_word     <= ram_rd_data;
          r_byte_idx <= '0;
        end
        S_SEND: begin
          if (w_hs) begin
`ifdef UART_DUMP_CHECKSUM_EN
            r_sum <= r_sum + uart_tx_data;
`endif
            if (w_last_byte) begin
              r_count <= r_count - (ADDR_LEN+1)'(1);
              if (!w_last_word) r_addr <= r_addr + ADDR_LEN'(1);
            end else begin
              r_byte_idx <= r_byte_idx + BIDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
